// File: rtl/pc_unit_ras_if.sv
// Request/status bundle between the fetch/branch logic (master) and pc_unit_ras (slave).
// PC-valued fields use [0:WIDTH-1] ordering: bit 0 is the MSB.
interface pc_unit_ras_if #(
  parameter int WIDTH = 32
) ();
  logic             stall;
  logic             branch_taken;
  logic [0:WIDTH-1] branch_target;
  logic             call;
  logic             ret;
  logic             exc;
  logic [0:WIDTH-1] pc;
  logic [0:WIDTH-1] pc_next_seq;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_err;
  logic             misalign;

  modport master (
    output stall, branch_taken, branch_target, call, ret, exc,
    input  pc, pc_next_seq, ras_empty, ras_full, ras_err, misalign
  );

  modport slave (
    input  stall, branch_taken, branch_target, call, ret, exc,
    output pc, pc_next_seq, ras_empty, ras_full, ras_err, misalign
  );
endinterface

// File: rtl/pc_unit_ras.sv
// Fetch PC with configurable increment, stall/branch/exception redirect and a circular
// return-address stack. Define PC_ALIGN_CHECK_EN to trap misaligned targets to EXC_VECTOR.
module pc_unit_ras #(
  parameter int               WIDTH        = 32,
  parameter int               INC          = 4,
  parameter logic [0:WIDTH-1] RESET_VECTOR = '0,
  parameter logic [0:WIDTH-1] EXC_VECTOR   = 32'h0000_0100,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  pc_unit_ras_if.slave  bus
);

  localparam int               PW       = $clog2(RAS_DEPTH);
  localparam int               CW       = $clog2(RAS_DEPTH + 1);
  localparam logic [0:WIDTH-1] INC_W    = WIDTH'(INC);
  localparam logic [0:WIDTH-1] LOW_MASK = INC_W - WIDTH'(1);
  localparam logic [CW-1:0]    FULL_CNT = CW'(RAS_DEPTH);

  logic [0:WIDTH-1] pc_q, pc_d;
  logic [PW-1:0]    sp_q, sp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [0:WIDTH-1] ras_q [RAS_DEPTH];
  logic [0:WIDTH-1] ras_d [RAS_DEPTH];
  logic             ras_err_q, ras_err_d;
  logic             misalign_q, misalign_d;

  logic [0:WIDTH-1] seq_pc;
  logic [0:WIDTH-1] ras_top;
  logic [0:WIDTH-1] br_tgt;
  logic [0:WIDTH-1] ret_tgt;
  logic [PW-1:0]    push_ptr;
  logic             ras_empty_c;
  logic             ras_full_c;
  logic             br_bad;
  logic             ret_bad;
  logic             tail_call;

  assign seq_pc      = pc_q + INC_W;
  assign ras_top     = ras_q[sp_q];
  assign push_ptr    = sp_q + PW'(1);
  assign ras_empty_c = (cnt_q == '0);
  assign ras_full_c  = (cnt_q == FULL_CNT);
  assign tail_call   = bus.branch_taken & bus.call;

`ifdef PC_ALIGN_CHECK_EN
  assign br_tgt  = bus.branch_target;
  assign ret_tgt = ras_top;
  assign br_bad  = |(bus.branch_target & LOW_MASK);
  assign ret_bad = |(ras_top & LOW_MASK);
`else
  // Without the check, loaded targets are silently forced onto the fetch grid.
  assign br_tgt  = bus.branch_target & ~LOW_MASK;
  assign ret_tgt = ras_top & ~LOW_MASK;
  assign br_bad  = 1'b0;
  assign ret_bad = 1'b0;
`endif

  always_comb begin
    pc_d       = pc_q;
    sp_d       = sp_q;
    cnt_d      = cnt_q;
    ras_d      = ras_q;
    ras_err_d  = 1'b0;
    misalign_d = 1'b0;

    if (bus.exc) begin
      pc_d = EXC_VECTOR;
    end else if (!bus.stall) begin
      if (bus.ret) begin
        if (ras_empty_c) begin
          pc_d      = seq_pc;
          ras_err_d = 1'b1;
        end else if (ret_bad) begin
          pc_d       = EXC_VECTOR;
          misalign_d = 1'b1;
          if (!tail_call) begin
            sp_d  = sp_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
          end
        end else begin
          pc_d = ret_tgt;
          // Tail call: the frame being returned from is replaced in place.
          if (tail_call) begin
            ras_d[sp_q] = seq_pc;
          end else begin
            sp_d  = sp_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
          end
        end
      end else if (bus.branch_taken) begin
        if (br_bad) begin
          pc_d       = EXC_VECTOR;
          misalign_d = 1'b1;
        end else begin
          pc_d = br_tgt;
          if (bus.call) begin
            // On a full stack, the slot after the top is the oldest entry.
            ras_d[push_ptr] = seq_pc;
            sp_d            = push_ptr;
            if (ras_full_c) begin
              ras_err_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end else begin
        pc_d = seq_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_VECTOR;
      sp_q       <= '0;
      cnt_q      <= '0;
      ras_err_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      sp_q       <= sp_d;
      cnt_q      <= cnt_d;
      ras_err_q  <= ras_err_d;
      misalign_q <= misalign_d;
    end
  end

  // Stack contents are meaningless while empty, so they need no reset.
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

  assign bus.pc          = pc_q;
  assign bus.pc_next_seq = seq_pc;
  assign bus.ras_empty   = ras_empty_c;
  assign bus.ras_full    = ras_full_c;
  assign bus.ras_err     = ras_err_q;
  assign bus.misalign    = misalign_q;

endmodule
